// File: rtl/ym6045c_cnt_n.sv
// ym6045c_cnt_n: parametrised loadable counter with carry chaining, auto-reload,
// registered terminal-count pulse and sticky overflow. Define YM6045C_CNT_DOWN_EN for i_dn.
module ym6045c_cnt_n #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RELOAD_INIT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_auto,
  input  logic             i_ovf_clr,
`ifdef YM6045C_CNT_DOWN_EN
  input  logic             i_dn,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qn,
  output logic             o_co,
  output logic             o_tc,
  output logic             o_ovf
);

  localparam logic [31:0]      RELOAD_INIT_W = RELOAD_INIT;
  localparam logic [WIDTH-1:0] RELOAD_RST    = RELOAD_INIT_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE           = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_val;
  logic             term;
  logic             wrap;
  logic             tc;
  logic             ovf;

  always_comb begin
    term     = (q == '1);
    step_val = q + ONE;
    wrap_val = '0;
`ifdef YM6045C_CNT_DOWN_EN
    if (i_dn) begin
      term     = (q == '0);
      step_val = q - ONE;
      wrap_val = '1;
    end
`endif
  end

  // clear and load both pre-empt a wrap, so neither raises tc/ovf
  assign wrap = i_en & term & ~i_clr & ~i_load;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q      <= '0;
      reload <= RELOAD_RST;
      tc     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      tc <= wrap;
      if (wrap)
        ovf <= 1'b1;
      else if (i_ovf_clr)
        ovf <= 1'b0;

      if (i_clr) begin
        q <= '0;
      end else if (i_load) begin
        q      <= i_d;
        reload <= i_d;
      end else if (i_en) begin
        if (term)
          q <= i_auto ? reload : wrap_val;
        else
          q <= step_val;
      end
    end
  end

  assign o_q   = q;
  assign o_qn  = ~q;
  assign o_co  = i_en & term;
  assign o_tc  = tc;
  assign o_ovf = ovf;

endmodule

// File: tb/tb_ym6045c_cnt_n.sv
// Directed self-checking bench for ym6045c_cnt_n: 8-bit instance plus a 2x4-bit cascade.
module tb_ym6045c_cnt_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, load, autom, ovf_clr;
  logic [7:0] d;
  logic [7:0] q, qn;
  logic       co, tc, ovf;
`ifdef YM6045C_CNT_DOWN_EN
  logic       dn;
`endif

  logic       c_en;
  logic [3:0] lo_q, lo_qn, hi_q, hi_qn;
  logic       lo_co, lo_tc, lo_ovf, hi_co, hi_tc, hi_ovf;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  ym6045c_cnt_n #(.WIDTH(8), .RELOAD_INIT(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load), .i_d(d),
    .i_auto(autom), .i_ovf_clr(ovf_clr),
`ifdef YM6045C_CNT_DOWN_EN
    .i_dn(dn),
`endif
    .o_q(q), .o_qn(qn), .o_co(co), .o_tc(tc), .o_ovf(ovf)
  );

  ym6045c_cnt_n #(.WIDTH(4), .RELOAD_INIT(0)) u_lo (
    .i_clk(clk), .i_rst(rst), .i_en(c_en), .i_clr(1'b0), .i_load(1'b0), .i_d(4'h0),
    .i_auto(1'b0), .i_ovf_clr(1'b0),
`ifdef YM6045C_CNT_DOWN_EN
    .i_dn(1'b0),
`endif
    .o_q(lo_q), .o_qn(lo_qn), .o_co(lo_co), .o_tc(lo_tc), .o_ovf(lo_ovf)
  );

  ym6045c_cnt_n #(.WIDTH(4), .RELOAD_INIT(0)) u_hi (
    .i_clk(clk), .i_rst(rst), .i_en(lo_co), .i_clr(1'b0), .i_load(1'b0), .i_d(4'h0),
    .i_auto(1'b0), .i_ovf_clr(1'b0),
`ifdef YM6045C_CNT_DOWN_EN
    .i_dn(1'b0),
`endif
    .o_q(hi_q), .o_qn(hi_qn), .o_co(hi_co), .o_tc(hi_tc), .o_ovf(hi_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned tc_seen;
    rst = 1'b1; en = 1'b1; clr = 1'b0; load = 1'b0; autom = 1'b0; ovf_clr = 1'b0;
    d = 8'h00; c_en = 1'b0;
`ifdef YM6045C_CNT_DOWN_EN
    dn = 1'b0;
`endif

    // 1. reset with enable held
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_q", q, 8'h00);
      chk("rst_qn", qn, 8'hFF);
      chk("rst_tc", tc, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_co", co, 1'b0);
    end
    rst = 1'b0;
    step();
    chk("rel_q", q, 8'h01);

    // 2. plain wrap
    en = 1'b0; load = 1'b1; d = 8'hFD;
    step();
    chk("ld_q", q, 8'hFD);
    load = 1'b0; en = 1'b1;
    step(); chk("w_q_fe", q, 8'hFE); chk("w_co_fe", co, 1'b0);
    step(); chk("w_q_ff", q, 8'hFF); chk("w_co_ff", co, 1'b1); chk("w_tc_ff", tc, 1'b0);
    chk("w_ovf_ff", ovf, 1'b0);
    step(); chk("w_q_00", q, 8'h00); chk("w_tc_00", tc, 1'b1); chk("w_ovf_00", ovf, 1'b1);
    step(); chk("w_q_01", q, 8'h01); chk("w_tc_01", tc, 1'b0); chk("w_ovf_01", ovf, 1'b1);

    // 3. auto-reload
    en = 1'b0; load = 1'b1; d = 8'hFE; autom = 1'b1;
    step(); chk("ar_ld", q, 8'hFE);
    load = 1'b0; en = 1'b1;
    step(); chk("ar_q1", q, 8'hFF); chk("ar_tc1", tc, 1'b0);
    step(); chk("ar_q2", q, 8'hFE); chk("ar_tc2", tc, 1'b1);
    step(); chk("ar_q3", q, 8'hFF); chk("ar_tc3", tc, 1'b0);
    step(); chk("ar_q4", q, 8'hFE); chk("ar_tc4", tc, 1'b1);
    en = 1'b0; ovf_clr = 1'b1;
    step(); chk("oc_ovf", ovf, 1'b0); chk("oc_q", q, 8'hFE); chk("oc_tc", tc, 1'b0);
    ovf_clr = 1'b0; en = 1'b1;
    step(); chk("sw_q", q, 8'hFF);
    ovf_clr = 1'b1;
    step(); chk("sw_ovf", ovf, 1'b1); chk("sw_q2", q, 8'hFE);
    ovf_clr = 1'b0;

    // 4. priority: load beats wrap, clear beats load
    step(); chk("pr_ff", q, 8'hFF);
    load = 1'b1; d = 8'h10;
    step(); chk("pr_ld_q", q, 8'h10); chk("pr_ld_tc", tc, 1'b0); chk("pr_ld_ovf", ovf, 1'b1);
    clr = 1'b1; d = 8'h33;
    step(); chk("pr_clr_q", q, 8'h00); chk("pr_clr_tc", tc, 1'b0);
    clr = 1'b0; load = 1'b0;
    for (int i = 0; i < 255; i++) step();
    chk("pr_cnt_ff", q, 8'hFF);
    step(); chk("pr_reload", q, 8'h10); chk("pr_rl_tc", tc, 1'b1);
    en = 1'b0;

    // 5. cascade of two 4-bit stages
    c_en = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("cs_0f", {hi_q, lo_q}, 8'h0F);
    chk("cs_co", lo_co, 1'b1);
    step(); chk("cs_10", {hi_q, lo_q}, 8'h10);
    tc_seen = 0;
    for (int i = 16; i < 255; i++) begin
      step();
      if (hi_tc) tc_seen++;
    end
    chk("cs_ff", {hi_q, lo_q}, 8'hFF);
    chk("cs_no_early_tc", tc_seen, 0);
    step(); chk("cs_wrap", {hi_q, lo_q}, 8'h00); chk("cs_hi_tc", hi_tc, 1'b1);
    c_en = 1'b0;
    step(); chk("cs_tc_end", hi_tc, 1'b0);

`ifdef YM6045C_CNT_DOWN_EN
    // 6. down count
    autom = 1'b0; load = 1'b1; d = 8'h02;
    step(); chk("dn_ld", q, 8'h02);
    load = 1'b0; en = 1'b1; dn = 1'b1;
    step(); chk("dn_01", q, 8'h01); chk("dn_co01", co, 1'b0);
    step(); chk("dn_00", q, 8'h00); chk("dn_co00", co, 1'b1);
    step(); chk("dn_ff", q, 8'hFF); chk("dn_tc", tc, 1'b1);
    en = 1'b0; dn = 1'b0;
`endif

    // asynchronous reset mid-count, no clock edge needed
    en = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    chk("ar_mid_q", q, 8'h00); chk("ar_mid_tc", tc, 1'b0); chk("ar_mid_ovf", ovf, 1'b0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
